// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word receiver: strobed 1-bit stream into WIDTH-bit words, MSB- or LSB-first.
// Optional even-parity check on a trailing bit when PARITY_CHECK_EN is defined.
module serial_word_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_first,
    input  logic             msb_first,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             overrun,
    output logic             m_perr
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_CHECK_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic             dir_q, dir_d;
    logic             done;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
    logic             perr_new;
    logic             m_perr_q, m_perr_d;
`endif

    always_comb begin
        shifted = dir_q ? {sreg_q[WIDTH-2:0], s_data} : {s_data, sreg_q[WIDTH-1:1]};
    end

    // Word assembly: s_first always restarts, even mid-word or on the parity slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        dir_d   = dir_q;
        done    = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_new = 1'b0;
`endif
        if (s_valid) begin
            if (s_first) begin
                state_d = SHIFT;
                cnt_d   = CW'(1);
                dir_d   = msb_first;
                sreg_d  = msb_first ? {{(WIDTH-1){1'b0}}, s_data}
                                    : {s_data, {(WIDTH-1){1'b0}}};
            end else begin
                case (state_q)
                    SHIFT: begin
                        sreg_d = shifted;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef PARITY_CHECK_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
                            done    = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: begin
                        state_d  = IDLE;
                        done     = 1'b1;
                        perr_new = (^sreg_q) ^ s_data;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Output register: a completion while full is dropped unless the held word leaves this cycle.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        overrun_d = 1'b0;
`ifdef PARITY_CHECK_EN
        m_perr_d  = m_perr_q;
`endif
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
            m_perr_d  = 1'b0;
`endif
        end
        if (done) begin
            if (!m_valid_q || m_ready) begin
                m_valid_d = 1'b1;
                m_data_d  = sreg_d;
`ifdef PARITY_CHECK_EN
                m_perr_d  = perr_new;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            dir_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            m_perr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            dir_q     <= dir_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            m_perr_q  <= m_perr_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign overrun = overrun_q;
`ifdef PARITY_CHECK_EN
    assign m_perr  = m_perr_q;
`else
    assign m_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=4); adds parity steps when
// PARITY_CHECK_EN is defined.
module tb_serial_word_deserializer;

    logic       clk = 1'b0;
    logic       rst, s_valid, s_data, s_first, msb_first, m_ready;
    logic       m_valid, overrun, m_perr;
    logic [3:0] m_data;

    int tests = 0;
    int fails = 0;

    serial_word_deserializer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_first   (s_first),
        .msb_first (msb_first),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .overrun   (overrun),
        .m_perr    (m_perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit; outputs reflecting it are visible on return.
    task automatic bit_(input logic b, input logic f, input logic msb);
        s_valid   = 1'b1;
        s_data    = b;
        s_first   = f;
        msb_first = msb;
        tick();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    // seq[3] is sent first; toggle flips msb_first on the non-first bits.
    task automatic send_bits(input logic [3:0] seq, input logic msb, input int gap,
                             input logic toggle);
        for (int i = 3; i >= 0; i--) begin
            bit_(seq[i], i == 3, (toggle && i != 3) ? ~msb : msb);
            if (i != 0) repeat (gap) tick();
        end
`ifdef PARITY_CHECK_EN
        bit_(^seq, 1'b0, msb);
`endif
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_first = 1'b0;
        msb_first = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 4'b0000);
        chk("reset_overrun", overrun, 0);
        chk("reset_m_perr", m_perr, 0);

        // Stray bit without s_first while idle is ignored.
        bit_(1'b1, 1'b0, 1'b1);
        tick();
        chk("idle_stray_m_valid", m_valid, 0);

        // MSB-first 1,0,1,0
        m_ready = 1'b1;
        bit_(1'b1, 1'b1, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
`ifdef PARITY_CHECK_EN
        bit_(1'b0, 1'b0, 1'b1);
        chk("msb_before_end_m_valid", m_valid, 0);
        bit_(1'b0, 1'b0, 1'b1);
`else
        chk("msb_before_end_m_valid", m_valid, 0);
        bit_(1'b0, 1'b0, 1'b1);
`endif
        chk("msb_m_valid", m_valid, 1);
        chk("msb_m_data", m_data, 4'b1010);
        chk("msb_overrun", overrun, 0);
        tick();
        chk("msb_accepted_m_valid", m_valid, 0);

        // LSB-first 1,0,1,1 with gaps, msb_first toggled mid-word
        send_bits(4'b1011, 1'b0, 3, 1'b1);
        chk("lsb_m_valid", m_valid, 1);
        chk("lsb_m_data", m_data, 4'b1101);
        tick();

        // Backpressure: second word dropped
        m_ready = 1'b0;
        send_bits(4'b1010, 1'b1, 0, 1'b0);
        chk("bp_first_m_data", m_data, 4'b1010);
        chk("bp_first_overrun", overrun, 0);
        send_bits(4'b0110, 1'b1, 0, 1'b0);
        chk("bp_overrun_pulse", overrun, 1);
        chk("bp_m_data_held", m_data, 4'b1010);
        chk("bp_m_valid_held", m_valid, 1);
        tick();
        chk("bp_overrun_one_cycle", overrun, 0);

        // Completion in the same cycle the held word is accepted
        bit_(1'b0, 1'b1, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
`ifdef PARITY_CHECK_EN
        bit_(1'b1, 1'b0, 1'b1);
        m_ready = 1'b1;
        bit_(1'b0, 1'b0, 1'b1);
`else
        m_ready = 1'b1;
        bit_(1'b1, 1'b0, 1'b1);
`endif
        chk("swap_m_valid", m_valid, 1);
        chk("swap_m_data", m_data, 4'b0101);
        chk("swap_overrun", overrun, 0);

        // Restart after two bits
        bit_(1'b1, 1'b1, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        send_bits(4'b0011, 1'b1, 0, 1'b0);
        chk("restart_m_data", m_data, 4'b0011);
        chk("restart_m_valid", m_valid, 1);
        chk("restart_overrun", overrun, 0);

        // Reset mid-word while holding a word
        m_ready = 1'b0;
        tick();
        chk("pre_rst_m_valid", m_valid, 1);
        bit_(1'b1, 1'b1, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 4'b0000);
        chk("rst_overrun", overrun, 0);
        // Remaining bits of the aborted word must not complete anything
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_tail_m_valid", m_valid, 0);

`ifdef PARITY_CHECK_EN
        m_ready = 1'b1;
        bit_(1'b1, 1'b1, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        chk("par_ok_m_valid", m_valid, 1);
        chk("par_ok_m_perr", m_perr, 0);
        tick();
        chk("par_ok_accept_m_valid", m_valid, 0);
        bit_(1'b1, 1'b1, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        bit_(1'b0, 1'b0, 1'b1);
        bit_(1'b1, 1'b0, 1'b1);
        chk("par_bad_m_valid", m_valid, 1);
        chk("par_bad_m_data", m_data, 4'b1010);
        chk("par_bad_m_perr", m_perr, 1);
        tick();
        chk("par_bad_cleared_m_perr", m_perr, 0);
`else
        chk("noparity_m_perr", m_perr, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
